uart_mem_bridge: RTL
====================

Name: uart_mem_bridge

Overview:
- Command engine between the UART receiver/transmitter and the core's single-port block RAM.
- Replaces hierarchical testbench pokes of the RAM port with a byte protocol over RX/TX.
- Decodes write/read packets, drives the RAM port, returns an ack byte or read data.
- Parametrised in data width, address width, RAM read latency and inter-byte timeout.

Parameters:
- DATA_W, 16, RAM word width in bits; a multiple of 8, from 8 to 32; DB = DATA_W/8 data bytes.
- ADDR_W, 15, RAM address width in bits, from 1 to 24; AB = ceil(ADDR_W/8) address bytes.
- RD_LAT, 1, RAM read latency in cycles from mem_en to valid mem_dout, from 1 to 3.
- TIMEOUT, 1000000, maximum clock cycles allowed between bytes inside a packet.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  byte offered; held until accepted
- tx_ready  in  1  transmitter idle; a transfer happens when tx_valid and tx_ready are both high
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable, one-cycle pulse
- mem_en  out  1  RAM read enable, one-cycle pulse
- mem_dout  in  DATA_W  RAM read data
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on a bad command byte or a timeout

Behaviour:
- Reset (asynchronous, any time, including mid-packet or mid-transmit):
  - All outputs go to 0; state goes to IDLE; byte counters and timeout counter clear.
  - A byte offered on TX is withdrawn.
- Packet format: command byte, then AB address bytes (MSB first), then, for writes only, DB data bytes (MSB first).
  - Command 0x57 ('W') = write; 0x52 ('R') = read.
  - Address bits above ADDR_W are discarded.
- IDLE:
  - rx_valid with 0x57 or 0x52 -> ADDR.
  - Any other byte -> err pulse on the next cycle; stay in IDLE.
- ADDR: shift each byte into the address register. After the AB-th byte -> DATA for a write, RD for a read.
- DATA: shift each byte into the data register. After the DB-th byte -> WR.
- WR:
  - One cycle: mem_we=1, mem_addr and mem_din driven from the registers.
  - Next state ACK, with tx_data=0x4B ('K') and tx_valid=1.
- ACK: hold tx_valid until tx_ready; on the transfer, tx_valid drops -> IDLE.
- RD:
  - One cycle with mem_en=1 -> RWAIT.
  - RWAIT counts RD_LAT cycles, then captures mem_dout into the shift register -> TX.
- TX:
  - Offer bytes MSB first, one per transfer; tx_valid stays high between bytes while tx_ready allows.
  - After the DB-th transfer -> IDLE.
- Write latency: mem_we is asserted exactly 1 cycle after the rx_valid of the last data byte.
- Read latency: first tx_valid is asserted RD_LAT+2 cycles after the rx_valid of the last address byte.
- Timeout:
  - In ADDR or DATA, a counter increments each cycle and clears on rx_valid.
  - Reaching TIMEOUT -> err pulse and IDLE; the partial packet is discarded and no RAM access occurs.
  - rx_valid in the same cycle as expiry: the byte wins and the counter clears.
- Bytes arriving in WR, RD, RWAIT, ACK or TX are dropped silently; no err pulse.
- mem_addr holds its last value between accesses. mem_we and mem_en are never high in the same cycle.

Test Plan:
- Write: bytes 57,00,01,AA,AA -> one mem_we pulse with addr=0x0001, din=0xAAAA; then TX byte 4B.
- Read back: after writes to 0002=5555 and 0003=CCCC, send 52,00,03 -> one mem_en pulse with addr=0x0003; TX bytes CC,CC. Repeat with RD_LAT=3 and check the extra latency.
- Bad command and timeout:
  - Byte 41 -> err pulse; busy stays 0.
  - Bytes 57,00 then idle for TIMEOUT cycles -> err pulse, return to IDLE, no mem_we.
- TX back-pressure: read of 0004=3333 with tx_ready held low for 50 cycles -> tx_valid=1 and tx_data=33 stable; two transfers total once tx_ready rises.
- Reset mid-packet: assert reset after 57,00,05 -> all outputs 0 immediately. Then 57,00,05,11,11 -> correct write.
- Parameter sweep: DATA_W=32, ADDR_W=10 -> 2 address bytes, 4 data bytes; addr bits [15:10] ignored; read returns 4 bytes MSB first.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// Byte-protocol command engine: decodes write/read packets from the UART receiver,
// drives a single-port RAM and answers with an ack byte or the read word.
module uart_mem_bridge #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy,
   output logic              err
);

   localparam int unsigned DB   = DATA_W / 8;
   localparam int unsigned AB   = (ADDR_W + 7) / 8;
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle, StAddr, StData, StWr, StAck, StRd, StRwait, StTx
   } state_e;

   state_e              state_q;
   logic                is_wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [2:0]          byte_cnt_q;
   logic [1:0]          lat_cnt_q;
   logic [TO_W-1:0]     to_cnt_q;
   logic [DATA_W-1:0]   data_shl;

   assign data_shl = data_q << 8;
   assign busy     = (state_q != StIdle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         byte_cnt_q <= '0;
         lat_cnt_q  <= '0;
         to_cnt_q   <= '0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_we     <= 1'b0;
         mem_en     <= 1'b0;
         err        <= 1'b0;
      end else begin
         err    <= 1'b0;
         mem_we <= 1'b0;
         mem_en <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rx_valid) begin
                  byte_cnt_q <= '0;
                  to_cnt_q   <= '0;
                  if (rx_data == 8'h57 || rx_data == 8'h52) begin
                     is_wr_q <= (rx_data == 8'h57);
                     state_q <= StAddr;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            StAddr, StData: begin
               // An arriving byte beats a simultaneous timeout expiry
               if (rx_valid) begin
                  to_cnt_q   <= '0;
                  byte_cnt_q <= byte_cnt_q + 3'd1;
                  if (state_q == StAddr) begin
                     addr_q <= ADDR_W'({addr_q, rx_data});
                     if (byte_cnt_q == 3'(AB - 1)) begin
                        byte_cnt_q <= '0;
                        if (is_wr_q) begin
                           state_q <= StData;
                        end else begin
                           state_q  <= StRd;
                           mem_en   <= 1'b1;
                           mem_addr <= ADDR_W'({addr_q, rx_data});
                        end
                     end
                  end else begin
                     data_q <= DATA_W'({data_q, rx_data});
                     if (byte_cnt_q == 3'(DB - 1)) begin
                        byte_cnt_q <= '0;
                        state_q    <= StWr;
                        mem_we     <= 1'b1;
                        mem_addr   <= addr_q;
                        mem_din    <= DATA_W'({data_q, rx_data});
                     end
                  end
               end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                  to_cnt_q <= '0;
                  err      <= 1'b1;
                  state_q  <= StIdle;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            StWr: begin
               tx_data  <= 8'h4B;
               tx_valid <= 1'b1;
               state_q  <= StAck;
            end
            StAck: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            StRd: begin
               lat_cnt_q <= '0;
               state_q   <= StRwait;
            end
            StRwait: begin
               if (lat_cnt_q == 2'(RD_LAT - 1)) begin
                  data_q     <= mem_dout;
                  tx_data    <= mem_dout[DATA_W-1 -: 8];
                  tx_valid   <= 1'b1;
                  byte_cnt_q <= '0;
                  state_q    <= StTx;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 2'd1;
               end
            end
            StTx: begin
               if (tx_ready) begin
                  if (byte_cnt_q == 3'(DB - 1)) begin
                     tx_valid <= 1'b0;
                     state_q  <= StIdle;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 3'd1;
                     data_q     <= data_shl;
                     tx_data    <= data_shl[DATA_W-1 -: 8];
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
